// File: rtl/dsa_pkg.sv
// Shared types and defaults for the bilinear DSA run controller.
package dsa_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_LAUNCH,
        S_RUN,
        S_REPORT
    } run_state_e;

    typedef enum logic [1:0] {
        STS_OK      = 2'd0,
        STS_BAD_CFG = 2'd1,
        STS_TIMEOUT = 2'd2,
        STS_ABORT   = 2'd3
    } run_sts_e;

    localparam int DEF_IN_W      = 64;
    localparam int DEF_IN_H      = 64;
    localparam int DEF_SCALE_Q88 = 205;

endpackage

// File: rtl/dsa_cfg_check.sv
// Combinational job validator: derives the scaled output size and checks that
// both the input and the output image fit in their RAMs.
module dsa_cfg_check #(
    parameter int AW      = 12,
    parameter int DIM_W   = 16,
    parameter int SCALE_W = 16
) (
    input  logic [DIM_W-1:0]   in_w,
    input  logic [DIM_W-1:0]   in_h,
    input  logic [SCALE_W-1:0] scale,
    output logic               ok,
    output logic [DIM_W-1:0]   out_w,
    output logic [DIM_W-1:0]   out_h
);

    localparam int PW = DIM_W + SCALE_W;
    localparam int OW = PW - 8;

    localparam logic [2*DIM_W-1:0] IN_CAP  = {{(2*DIM_W-1){1'b0}}, 1'b1} << AW;
    localparam logic [2*OW-1:0]    OUT_CAP = {{(2*OW-1){1'b0}}, 1'b1} << AW;

    logic [PW-1:0]      prod_w;
    logic [PW-1:0]      prod_h;
    logic [OW-1:0]      full_w;
    logic [OW-1:0]      full_h;
    logic [2*DIM_W-1:0] in_area;
    logic [2*OW-1:0]    out_area;

    // Full-width products; the Q8.8 fraction is dropped only after multiplying.
    assign prod_w   = {{SCALE_W{1'b0}}, in_w} * {{DIM_W{1'b0}}, scale};
    assign prod_h   = {{SCALE_W{1'b0}}, in_h} * {{DIM_W{1'b0}}, scale};
    assign full_w   = OW'(prod_w >> 8);
    assign full_h   = OW'(prod_h >> 8);
    assign in_area  = {{DIM_W{1'b0}}, in_w} * {{DIM_W{1'b0}}, in_h};
    assign out_area = {{OW{1'b0}}, full_w} * {{OW{1'b0}}, full_h};

    assign ok = (in_w != '0) && (in_h != '0) && (scale != '0) &&
                (in_area <= IN_CAP) &&
                (full_w != '0) && (full_h != '0) &&
                (out_area <= OUT_CAP);

    assign out_w = full_w[DIM_W-1:0];
    assign out_h = full_h[DIM_W-1:0];

endmodule

// File: rtl/dsa_run_ctrl.sv
// Run controller for the bilinear DSA: validates a job, launches the core,
// supervises it with a cycle counter, timeout and abort, and reports status.
module dsa_run_ctrl
    import dsa_pkg::*;
#(
    parameter int AW         = 12,
    parameter int DIM_W      = 16,
    parameter int SCALE_W    = 16,
    parameter int TMO_CYCLES = 5_000_000,
    parameter int CNT_W      = 32
) (
    input  logic               clk_50,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [DIM_W-1:0]   cmd_in_w,
    input  logic [DIM_W-1:0]   cmd_in_h,
    input  logic [SCALE_W-1:0] cmd_scale_q88,
    input  logic               abort,
    output logic [DIM_W-1:0]   core_in_w,
    output logic [DIM_W-1:0]   core_in_h,
    output logic [SCALE_W-1:0] core_scale_q88,
    output logic               core_start,
    output logic               core_clr,
    input  logic               core_done,
    output logic               busy,
    output logic               sts_valid,
    output logic [1:0]         sts_code,
    output logic [CNT_W-1:0]   sts_cycles,
    output logic [DIM_W-1:0]   sts_out_w,
    output logic [DIM_W-1:0]   sts_out_h
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TMO_CYCLES);

    run_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [DIM_W-1:0] out_w_q;
    logic [DIM_W-1:0] out_h_q;
    logic             chk_ok;
    logic [DIM_W-1:0] chk_out_w;
    logic [DIM_W-1:0] chk_out_h;
    logic             run_timeout;

    dsa_cfg_check #(
        .AW      (AW),
        .DIM_W   (DIM_W),
        .SCALE_W (SCALE_W)
    ) u_cfg_check (
        .in_w  (core_in_w),
        .in_h  (core_in_h),
        .scale (core_scale_q88),
        .ok    (chk_ok),
        .out_w (chk_out_w),
        .out_h (chk_out_h)
    );

    assign cnt_inc     = (cnt == '1) ? cnt : cnt + 1'b1;
    assign run_timeout = (cnt == TMO);

    // The clear must coincide with the RUN cycle that decides to stop, so it
    // is the one output decoded from state rather than held in a flop.
    assign core_clr = (state == S_RUN) && !core_done && (run_timeout || abort);

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            cnt            <= '0;
            out_w_q        <= '0;
            out_h_q        <= '0;
            cmd_ready      <= 1'b0;
            busy           <= 1'b0;
            core_in_w      <= '0;
            core_in_h      <= '0;
            core_scale_q88 <= '0;
            core_start     <= 1'b0;
            sts_valid      <= 1'b0;
            sts_code       <= STS_OK;
            sts_cycles     <= '0;
            sts_out_w      <= '0;
            sts_out_h      <= '0;
        end else begin
            core_start <= 1'b0;
            sts_valid  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_ready && cmd_valid) begin
                        core_in_w      <= cmd_in_w;
                        core_in_h      <= cmd_in_h;
                        core_scale_q88 <= cmd_scale_q88;
                        cmd_ready      <= 1'b0;
                        busy           <= 1'b1;
                        state          <= S_CHECK;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                S_CHECK: begin
                    out_w_q <= chk_out_w;
                    out_h_q <= chk_out_h;
                    if (!chk_ok) begin
                        sts_code   <= STS_BAD_CFG;
                        sts_cycles <= '0;
                        sts_out_w  <= chk_out_w;
                        sts_out_h  <= chk_out_h;
                        sts_valid  <= 1'b1;
                        state      <= S_REPORT;
                    end else begin
                        cnt        <= '0;
                        core_start <= 1'b1;
                        state      <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    cnt   <= cnt_inc;
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (core_done || run_timeout || abort) begin
                        if (core_done) begin
                            sts_code <= STS_OK;
                        end else if (run_timeout) begin
                            sts_code <= STS_TIMEOUT;
                        end else begin
                            sts_code <= STS_ABORT;
                        end
                        sts_cycles <= cnt;
                        sts_out_w  <= out_w_q;
                        sts_out_h  <= out_h_q;
                        sts_valid  <= 1'b1;
                        state      <= S_REPORT;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_REPORT: begin
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    cmd_ready <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dsa_run_ctrl.md
# dsa_run_ctrl

Run controller for the sequential bilinear DSA. It accepts a job command (input width, input height, Q8.8 scale) and validates it against RAM depth. It then drives the core's configuration and start pulse, supervises the run with a cycle counter, a timeout and an abort, and reports one status record per job. It sits between the board-level start/host logic and the bilinear core, replacing the hard-wired `*_INIT` configuration.

## Interface
- `AW`, 12: address width of the input and output image RAMs; the capacity is 2**AW pixels each.
- `DIM_W`, 16: width of the dimension fields.
- `SCALE_W`, 16: width of the Q8.8 scale field.
- `TMO_CYCLES`, 5_000_000: maximum number of RUN cycles before a timeout.
- `CNT_W`, 32: width of the run cycle counter.

Ports:
- `clk_50`  in  1  single system clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `cmd_valid`  in  1  job request.
- `cmd_ready`  out  1  controller can accept a job; high only in IDLE.
- `cmd_in_w`, `cmd_in_h`  in  DIM_W  input image size.
- `cmd_scale_q88`  in  SCALE_W  scale factor in Q8.8.
- `abort`  in  1  cancels the running job; sampled only in RUN.
- `core_in_w`, `core_in_h`, `core_scale_q88`  out  DIM_W/DIM_W/SCALE_W  registered config; stable from accept until the next accept.
- `core_start`  out  1  one-cycle start pulse to the core.
- `core_clr`  out  1  one-cycle soft clear to the core on timeout or abort.
- `core_done`  in  1  core completion level; held high until the next start.
- `busy`  out  1  high in every state except IDLE.
- `sts_valid`  out  1  one-cycle pulse announcing a completed job.
- `sts_code`  out  2  job result: 0 OK, 1 BAD_CFG, 2 TIMEOUT, 3 ABORT.
- `sts_cycles`  out  CNT_W  number of RUN cycles consumed by the job.
- `sts_out_w`, `sts_out_h`  out  DIM_W  computed output size.

## Operation
- The FSM has five states: IDLE, CHECK, LAUNCH, RUN, REPORT.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`, capture the three fields into the `core_*` registers and go to CHECK.
- **CHECK** (exactly 1 cycle)
  - Compute `out_w = (in_w*scale)>>8` and `out_h = (in_h*scale)>>8`. Products use the full DIM_W+SCALE_W width with no truncation before the shift.
  - The job is BAD_CFG if any of the following holds: `in_w`==0; `in_h`==0; `scale`==0; `in_w*in_h > 2**AW`; `out_w`==0; `out_h`==0; `out_w*out_h > 2**AW`.
  - If BAD_CFG: go to REPORT with `sts_cycles`=0. Otherwise go to LAUNCH.
  - `sts_out_w`/`sts_out_h` are loaded in both cases.
- **LAUNCH**: `core_start`=1 for this single cycle; the cycle counter is cleared.
- **RUN**
  - The counter increments every cycle; the first RUN cycle counts as 1.
  - Exit conditions, highest priority first:
    - `core_done`=1: go to REPORT with code OK.
    - Counter == `TMO_CYCLES`: pulse `core_clr`, go to REPORT with code TIMEOUT.
    - `abort`=1: pulse `core_clr`, go to REPORT with code ABORT.
  - Done in the same cycle as a timeout or abort reports OK.
- **REPORT** (1 cycle)
  - `sts_valid`=1; then go to IDLE.
  - `sts_code`, `sts_cycles` and `sts_out_*` hold their values until the next REPORT.
- `abort` outside RUN has no effect. `cmd_valid` outside IDLE is ignored and is not queued.
- The counter saturates at all-ones and never wraps.

## Timing
- All outputs reset to 0. `cmd_ready` becomes 1 on the first clock edge after `rst_n` deasserts (IDLE).
- For a valid job accepted at edge 0:
  - CHECK at cycle 1.
  - `core_start` high at cycle 2.
  - RUN from cycle 3.
  - If `core_done` is first seen high at cycle N, `sts_valid` is high at N+1 and `cmd_ready` at N+2.
- BAD_CFG job accepted at 0: `sts_valid` at cycle 2, `cmd_ready` at cycle 3.
- `core_clr` is asserted in the same cycle as the timeout or abort decision; `sts_valid` follows one cycle later.
- If `rst_n` is asserted mid-job, all state is cleared immediately. No `sts_valid` is produced, and the `core_*` config returns to 0.

## Structure
- Shared package `dsa_pkg` holds:
  - the state enum `run_state_e`;
  - the status enum `run_sts_e` (OK, BAD_CFG, TIMEOUT, ABORT);
  - localparams for the default 64x64 size and scale 205.
- Sub-module `dsa_cfg_check`: combinational validator from (w, h, scale) to (ok, out_w, out_h), parameterised on AW/DIM_W/SCALE_W. Its outputs are registered in the parent at the CHECK edge.

## Test plan
- 64x64, scale 205; core model raises done 4000 cycles after start → `core_start` at cycle 2, `sts_code`=OK, `sts_cycles`=4000, `sts_out_w`=`sts_out_h`=51.
- 64x65 (4160 > 4096), scale 256 → BAD_CFG, `sts_valid` at cycle 2, no `core_start`. Repeat with scale 0 → BAD_CFG.
- 64x64, scale 512 (out 128x128 > 4096) → BAD_CFG. Then 32x32, scale 512 → OK with out 64x64.
- `TMO_CYCLES`=100, core never done → `core_clr` pulse with `sts_cycles`=100, `sts_code`=TIMEOUT, followed by `cmd_ready`.
- Abort at RUN cycle 10 → ABORT with `sts_cycles`=10. Abort and done in the same cycle → OK. Abort pulsed in IDLE → no effect.
- Assert `rst_n`=0 mid-RUN → all outputs 0 and no `sts_valid`. A new job after release completes OK.
